usart_tx: RTL and testbench
===========================

# usart_tx

Byte-oriented asynchronous serial transmitter: accepts parallel words through a small write FIFO and shifts each out on `tx` as an 8N1-style frame (start bit, DATA_BIT data bits LSB first, optional parity, one stop bit). It is the transmit companion of the USART receiver, shares its CLK_FREQ/BAUD_RATE/DATA_BIT parameterisation, and sits between the host-side logic and the board TX pin.

## Interface
- CLK_FREQ, 100000000, system clock frequency in Hz
- BAUD_RATE, 115200, line rate in bit/s
- DATA_BIT, 8, data bits per frame, 1..8; data[DATA_BIT-1:0] sent, upper bits ignored
- FIFO_DEPTH, 4, write FIFO entries, power of two, 2..16
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- data  input  8  word to transmit
- wr_en  input  1  write strobe; accepted on a rising edge when wr_en && !full
- full  output  1  FIFO holds FIFO_DEPTH entries
- empty  output  1  FIFO holds no entries
- overflow  output  1  one-cycle pulse: wr_en while full, word dropped
- busy  output  1  a frame is on the line
- tx_done  output  1  one-cycle pulse at the end of each frame's stop bit
- tx  output  1  serial line, idle high, registered

## Operation
- CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division); every bit period is exactly CLKS_PER_BIT cycles. Bit counter wide enough for CLKS_PER_BIT-1; no dependence on a fixed 12-bit width.
- FIFO: circular buffer, read/write pointers wrap modulo FIFO_DEPTH, occupancy count 0..FIFO_DEPTH. Simultaneous push and pop permitted; count unchanged. `full` evaluated on current registered count: a write while full is rejected even if a pop occurs the same edge.
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
  - IDLE: tx=1. If FIFO non-empty: pop head into shift register, -> START.
  - START: tx=0 for CLKS_PER_BIT, -> DATA, bit index 0.
  - DATA: tx=shift[index]; after CLKS_PER_BIT, index+1; after bit DATA_BIT-1 -> PARITY or STOP.
  - STOP: tx=1 for CLKS_PER_BIT; on last cycle pulse tx_done; if FIFO non-empty pop and -> START (no idle gap), else -> IDLE.
- busy = (state != IDLE).
- Reset (any time, including mid-frame): FSM -> IDLE, FIFO flushed, counters cleared; in-flight frame truncated, line returns high next edge.
- Reset values: tx=1, full=0, empty=1, overflow=0, busy=0, tx_done=0.

## Timing
- Write into empty FIFO while IDLE at edge N: empty=0 after N, pop and tx falls at edge N+1, busy=1 after N+1, empty=1 after N+1.
- Frame duration: (2 + DATA_BIT [+1 parity]) × CLKS_PER_BIT cycles from tx falling edge to start of next frame/idle.
- tx_done high during the final cycle of STOP; next frame's start bit begins the following edge when FIFO non-empty.
- overflow pulses in the same cycle after the rejected write edge; FIFO contents unaffected.
- tx changes only on bit-period boundaries; no glitches (registered output).

## Configuration
- USART_TX_PARITY_EN defined: PARITY state inserted after data bits; tx = XOR of data[DATA_BIT-1:0] (even parity) for CLKS_PER_BIT; frame length +1 bit.
- Undefined: no PARITY state, DATA -> STOP directly; frame length 2+DATA_BIT bits.

## Test plan
- CLK_FREQ=1000000, BAUD_RATE=100000 (10 clk/bit), write 0xA5 -> tx: low 10 clk, then 1,0,1,0,0,1,0,1 each 10 clk, high 10 clk; tx_done one pulse at cycle 100 after tx fall; busy drops next edge.
- Write 0x01,0x02,0x03 on consecutive cycles -> three frames back-to-back, stop bit exactly 10 clk between them, three tx_done pulses 100 clk apart, empty=1 after third pop.
- FIFO_DEPTH=4, 6 writes on consecutive cycles while first frame starts -> 5 accepted (one popped immediately), 6th gets overflow pulse and full=1; 5 frames transmitted in order.
- Assert reset for one cycle mid-DATA of 0xFF -> tx=1 next edge, busy=0, empty=1, no tx_done; subsequent write of 0x3C transmits a clean frame.
- DATA_BIT=5, write 0xFF -> only 5 data bits (all 1) sent, frame 70 clk.
- USART_TX_PARITY_EN defined, write 0x07 -> parity bit 1 after data, frame 110 clk; write 0x03 -> parity bit 0.

Source files
------------

// File: rtl/usart_tx.sv
// Asynchronous serial transmitter: write FIFO feeding a start/data/stop frame shifter on tx.
// Optional even-parity bit after the data bits when USART_TX_PARITY_EN is defined.
module usart_tx #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BIT   = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       wr_en,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int unsigned CPB   = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef USART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          bit_q, bit_d;
  logic [DATA_BIT-1:0] shift_q, shift_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic                tx_q, tx_d;
  logic                tx_done_q, tx_done_d;
  logic                overflow_q, overflow_d;
`ifdef USART_TX_PARITY_EN
  logic                par_q, par_d;
`endif
  logic [DATA_BIT-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BIT-1:0] head;
  logic                push, pop, bit_end;

  assign full     = (occ_q == OCC_W'(FIFO_DEPTH));
  assign empty    = (occ_q == '0);
  assign busy     = (state_q != IDLE);
  assign tx       = tx_q;
  assign tx_done  = tx_done_q;
  assign overflow = overflow_q;
  assign head     = mem_q[rd_ptr_q];
  assign push     = wr_en && !full;
  assign bit_end  = (cnt_q == CNT_W'(CPB - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef USART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
`ifdef USART_TX_PARITY_EN
          par_d   = ^head;
`endif
          state_d = START;
        end
      end
      START: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 4'(DATA_BIT - 1)) begin
`ifdef USART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef USART_TX_PARITY_EN
      PARITY: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
`ifdef USART_TX_PARITY_EN
            par_d   = ^head;
`endif
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level and done pulse follow the next state so both come straight from flops.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef USART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
    tx_done_d  = (state_d == STOP) && (cnt_d == CNT_W'(CPB - 1));
    overflow_d = wr_en && full;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
      overflow_q <= 1'b0;
`ifdef USART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
      overflow_q <= overflow_d;
`ifdef USART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data[DATA_BIT-1:0];
  end

endmodule

// File: tb/tb_usart_tx.sv
// Bench for usart_tx: directed and random bursts checked cycle-by-cycle against a frame model.
module tb_usart_tx;

  localparam int unsigned CPB   = 10;
  localparam int unsigned DEPTH = 4;
`ifdef USART_TX_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int unsigned F8 = (2 + 8 + PAR) * CPB;
  localparam int unsigned F5 = (2 + 5 + PAR) * CPB;

  logic       clk = 1'b0, reset = 1'b1, wr_en = 1'b0, wr_en5 = 1'b0;
  logic [7:0] data = '0, data5 = '0;
  logic       full, empty, overflow, busy, tx_done, tx;
  logic       full5, empty5, overflow5, busy5, tx_done5, tx5;

  int npass = 0, nfail = 0, ntot = 0;
  logic [7:0] wq[$];
  logic [7:0] sb[$];
  int unsigned skip_g;

  usart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BIT(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .data(data), .wr_en(wr_en), .full(full), .empty(empty),
    .overflow(overflow), .busy(busy), .tx_done(tx_done), .tx(tx));

  usart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BIT(5), .FIFO_DEPTH(4)) dut5 (
    .clk(clk), .reset(reset), .data(data5), .wr_en(wr_en5), .full(full5), .empty(empty5),
    .overflow(overflow5), .busy(busy5), .tx_done(tx_done5), .tx(tx5));

  always #5 clk = ~clk;

  // Line level in bit slot k of a frame carrying byte b with db data bits.
  function automatic logic exp_line(input logic [7:0] b, input int unsigned db, input int unsigned k);
    int unsigned m;
    m = int'(b) & ((1 << db) - 1);
    if (k == 0) return 1'b0;
    if (k <= db) return ((m >> (k - 1)) % 2) == 1;
    if (PAR == 1 && k == db + 1) return ($countones(m) % 2) == 1;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    ntot++;
    assert (obs === exp_v) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Writes wq on consecutive cycles starting from an idle, empty transmitter.
  task automatic burst();
    int unsigned occ;
    bit acc;
    occ = 0;
    for (int i = 0; i < wq.size(); i++) begin
      data  = wq[i];
      wr_en = 1'b1;
      @(negedge clk);
      acc = (occ < DEPTH);
      if (acc) sb.push_back(wq[i]);
      occ = occ + (acc ? 1 : 0) - ((i == 1) ? 1 : 0);
      chk("overflow", overflow, !acc);
      chk("full", full, occ == DEPTH);
      chk("empty", empty, occ == 0);
    end
    wr_en  = 1'b0;
    skip_g = (wq.size() > 1) ? wq.size() - 1 : 0;
    wq.delete();
  endtask

  task automatic check_frame(input int unsigned skip, input int unsigned upto);
    logic [7:0] b;
    int unsigned w;
    b = sb.pop_front();
    if (skip == 0) begin
      w = 0;
      @(negedge clk);
      while (tx !== 1'b0 && w < 200) begin
        w++;
        @(negedge clk);
      end
      chk("start_latency", w, 0);
      chk("start_empty", empty, sb.size() == 0);
      chk("start_full", full, sb.size() == DEPTH);
    end
    for (int unsigned c = skip; c < upto; c++) begin
      if (skip != 0 || c != 0) @(negedge clk);
      chk("tx_bit", tx, exp_line(b, 8, c / CPB));
      chk("tx_done", tx_done, c == F8 - 1);
      chk("busy", busy, 1'b1);
    end
  endtask

  task automatic frames();
    bit first;
    first = 1'b1;
    while (sb.size() > 0) begin
      check_frame(first ? skip_g : 0, F8);
      first = 1'b0;
    end
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_tx", tx, 1'b1);
    chk("idle_empty", empty, 1'b1);
    chk("idle_tx_done", tx_done, 1'b0);
  endtask

  initial begin
    int unsigned w, n;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_done", tx_done, 1'b0);
    chk("rst_tx5", tx5, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    wq.push_back(8'hA5);
    burst();
    frames();

    wq = '{8'h01, 8'h02, 8'h03};
    burst();
    frames();

    repeat (6) wq.push_back(8'($urandom));
    burst();
    frames();

    wq.push_back(8'hFF);
    burst();
    check_frame(0, 35);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_empty", empty, 1'b1);
    chk("midrst_full", full, 1'b0);
    chk("midrst_tx_done", tx_done, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("postrst_tx", tx, 1'b1);
      chk("postrst_tx_done", tx_done, 1'b0);
    end
    wq.push_back(8'h3C);
    burst();
    frames();

    wq.push_back(8'h07);
    burst();
    frames();
    wq.push_back(8'h03);
    burst();
    frames();

    data5  = 8'hFF;
    wr_en5 = 1'b1;
    @(negedge clk);
    wr_en5 = 1'b0;
    w = 0;
    @(negedge clk);
    while (tx5 !== 1'b0 && w < 200) begin
      w++;
      @(negedge clk);
    end
    chk("db5_start_latency", w, 0);
    for (int unsigned c = 0; c < F5; c++) begin
      if (c != 0) @(negedge clk);
      chk("db5_tx_bit", tx5, exp_line(8'hFF, 5, c / CPB));
      chk("db5_tx_done", tx_done5, c == F5 - 1);
    end
    @(negedge clk);
    chk("db5_idle_busy", busy5, 1'b0);
    chk("db5_idle_tx", tx5, 1'b1);

    repeat (6) begin
      n = $urandom_range(1, 6);
      repeat (n) wq.push_back(8'($urandom));
      burst();
      frames();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
